// File: rtl/memory_io_unit.sv
// Memory and I/O subsystem for the multicycle processor: unified word RAM,
// memory-mapped I/O registers and a streaming boot loader that gates processor reset.
module memory_io_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [19:0]       Daddress,
  input  logic [19:0]       Dout,
  input  logic              W,
  output logic [19:0]       DataIn,
  input  logic              load_valid,
  input  logic [19:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              proc_reset,
  input  logic [19:0]       in_port,
  output logic [19:0]       out_port,
  output logic [ADDR_W:0]   boot_words
);

  localparam logic [19:0]       IO_OUT    = 20'hFFFF0;
  localparam logic [19:0]       IO_IN     = 20'hFFFF1;
  localparam logic [19:0]       IO_CNT    = 20'hFFFF2;
  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   WORDS_ONE = 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [19:0]       mem [0:(1<<ADDR_W)-1];
  logic [19:0]       in_meta;
  logic [19:0]       in_sync;
  logic [19:0]       cycle_cnt;
  logic              ram_sel;
  logic [ADDR_W-1:0] idx;

  assign idx     = Daddress[ADDR_W-1:0];
  assign ram_sel = (Daddress[19:ADDR_W] == '0);

  // RAM kept in its own reset-free block so its contents survive Reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state == BOOT && load_valid)
        mem[ptr] <= load_data;
      else if (state == RUN && W && ram_sel)
        mem[idx] <= Dout;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= BOOT;
      ptr        <= '0;
      boot_words <= '0;
      out_port   <= '0;
      cycle_cnt  <= '0;
      in_meta    <= '0;
      in_sync    <= '0;
      load_ready <= 1'b1;
      proc_reset <= 1'b1;
    end else begin
      in_meta    <= in_port;
      in_sync    <= in_meta;
      // Lags state by one edge so the processor sees one reset cycle in RUN.
      proc_reset <= (state == BOOT);
      case (state)
        BOOT: begin
          if (load_valid) begin
            ptr        <= ptr + PTR_ONE;
            boot_words <= boot_words + WORDS_ONE;
            if (load_last || ptr == '1) begin
              state      <= RUN;
              load_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + 20'd1;
          if (W && Daddress == IO_OUT)
            out_port <= Dout;
        end
      endcase
    end
  end

  always_comb begin
    DataIn = '0;
    if (ram_sel) begin
      DataIn = mem[idx];
    end else begin
      case (Daddress)
        IO_OUT:  DataIn = out_port;
        IO_IN:   DataIn = in_sync;
        IO_CNT:  DataIn = cycle_cnt;
        default: DataIn = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_io_unit.sv
// Self-checking bench for memory_io_unit: directed scenarios plus random RUN traffic
// against a behavioural model of the address map, loader and I/O timing.
module tb_memory_io_unit;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [19:0]   Daddress = '0;
  logic [19:0]   Dout = '0;
  logic          W = 1'b0;
  logic [19:0]   DataIn;
  logic          load_valid = 1'b0;
  logic [19:0]   load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          proc_reset;
  logic [19:0]   in_port = '0;
  logic [19:0]   out_port;
  logic [AW:0]   boot_words;

  int errors = 0;
  int checks = 0;

  memory_io_unit #(.ADDR_W(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Daddress(Daddress), .Dout(Dout), .W(W),
    .DataIn(DataIn), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .proc_reset(proc_reset),
    .in_port(in_port), .out_port(out_port), .boot_words(boot_words)
  );

  always #5 Clock = ~Clock;

  // Behavioural model
  logic [19:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  bit          m_run  = 1'b0;
  bit          m_prst = 1'b1;
  bit          m_ok   = 1'b0;
  int          m_ptr  = 0;
  int          m_words = 0;
  logic [19:0] m_out = '0;
  logic [19:0] m_cnt = '0;
  logic [19:0] m_inq [$];

  function automatic logic [19:0] m_read(input logic [19:0] a);
    logic [3:0] i;
    i = a[3:0];
    if (a < DEPTH)          return m_mem[i];
    if (a == 20'hFFFF0)     return m_out;
    if (a == 20'hFFFF1)     return m_inq[0];
    if (a == 20'hFFFF2)     return m_cnt;
    return 20'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    if (Reset) begin
      m_run = 1'b0; m_prst = 1'b1; m_ptr = 0; m_words = 0;
      m_out = '0; m_cnt = '0; m_inq = '{20'd0, 20'd0}; m_ok = 1'b1;
    end else begin
      m_prst = !m_run;
      if (m_run) begin
        m_cnt = m_cnt + 20'd1;
        if (W) begin
          if (Daddress < DEPTH) begin
            m_mem[Daddress[3:0]] = Dout;
            m_val[Daddress[3:0]] = 1'b1;
          end else if (Daddress == 20'hFFFF0) begin
            m_out = Dout;
          end
        end
      end else if (load_valid) begin
        m_mem[m_ptr] = load_data;
        m_val[m_ptr] = 1'b1;
        m_words++;
        if (load_last || m_ptr == DEPTH - 1) m_run = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      m_inq.push_back(in_port);
      void'(m_inq.pop_front());
    end
  end

  always @(negedge Clock) begin
    if (m_ok) begin
      check("load_ready", {31'd0, load_ready}, {31'd0, !m_run});
      check("proc_reset", {31'd0, proc_reset}, {31'd0, m_prst});
      check("out_port", {12'd0, out_port}, {12'd0, m_out});
      check("boot_words", {27'd0, boot_words}, m_words);
      if (Daddress >= DEPTH || m_val[Daddress[3:0]])
        check("DataIn", {12'd0, DataIn}, {12'd0, m_read(Daddress)});
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle();
    load_valid = 1'b0; load_last = 1'b0; W = 1'b0;
  endtask

  task automatic rd(input string name, input logic [19:0] a, input logic [19:0] exp);
    Daddress = a;
    #1;
    check(name, {12'd0, DataIn}, {12'd0, exp});
  endtask

  initial begin
    logic [19:0] bw [3];
    bw[0] = 20'h00001; bw[1] = 20'hD1230; bw[2] = 20'hFFFFF;

    idle(); cyc(); cyc(); #1;
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_proc_reset", {31'd0, proc_reset}, 32'd1);
    check("rst_out_port", {12'd0, out_port}, 32'd0);
    check("rst_boot_words", {27'd0, boot_words}, 32'd0);

    // Three-word boot
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = bw[i]; load_last = (i == 2);
      cyc();
    end
    idle(); #1;
    check("boot3_words", {27'd0, boot_words}, 32'd3);
    check("boot3_ready", {31'd0, load_ready}, 32'd0);
    check("boot3_prst_first", {31'd0, proc_reset}, 32'd1);
    rd("cnt_first_run", 20'hFFFF2, 20'd0);
    cyc(); #1;
    check("boot3_prst_drop", {31'd0, proc_reset}, 32'd0);
    repeat (9) cyc();
    rd("cnt_ten", 20'hFFFF2, 20'd10);
    for (int i = 0; i < 3; i++) rd("boot3_ram", i[19:0], bw[i]);

    // RAM write/read, unmapped write, same-cycle read-before-write
    Daddress = 20'h00005; Dout = 20'hABCDE; W = 1'b1; cyc(); W = 1'b0;
    rd("ram5_wr", 20'h00005, 20'hABCDE);
    Daddress = 20'h00105; W = 1'b1; cyc(); W = 1'b0;
    rd("unmapped", 20'h00105, 20'h0);
    rd("ram5_keep", 20'h00005, 20'hABCDE);
    Dout = 20'h11111; W = 1'b1;
    rd("ram5_old", 20'h00005, 20'hABCDE);
    cyc(); W = 1'b0;
    rd("ram5_new", 20'h00005, 20'h11111);

    // I/O
    Daddress = 20'hFFFF0; Dout = 20'h0F0F0; W = 1'b1; cyc(); W = 1'b0; #1;
    check("out_port_wr", {12'd0, out_port}, 32'h0F0F0);
    rd("in_k", 20'hFFFF1, 20'h0);
    in_port = 20'h12345;
    rd("in_k0", 20'hFFFF1, 20'h0);
    cyc();
    rd("in_k1", 20'hFFFF1, 20'h0);
    cyc();
    rd("in_k2", 20'hFFFF1, 20'h12345);
    Dout = 20'h0; W = 1'b1; cyc(); W = 1'b0;
    rd("in_ro", 20'hFFFF1, 20'h12345);

    // Random RUN traffic (RAM[0..2] left untouched)
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: Daddress = 20'($urandom_range(3, 15));
        3:       Daddress = 20'hFFFF0 + 20'($urandom_range(0, 3));
        4:       Daddress = 20'h00100 | 20'($urandom_range(0, 15));
        default: Daddress = 20'($urandom_range(16, 20'hFFFEF));
      endcase
      W = 1'($urandom_range(0, 1));
      Dout = 20'($urandom);
      in_port = 20'($urandom);
      load_valid = 1'($urandom_range(0, 1));
      load_last = 1'($urandom_range(0, 1));
      load_data = 20'($urandom);
      cyc();
    end
    idle();

    // Counter wrap
    Daddress = 20'hFFFF2;
    force dut.cycle_cnt = 20'hFFFFF;
    m_cnt = 20'hFFFFF;
    #1 release dut.cycle_cnt;
    rd("cnt_preset", 20'hFFFF2, 20'hFFFFF);
    cyc();
    rd("cnt_wrap", 20'hFFFF2, 20'h0);

    // Reset mid-RUN with a RAM write pending
    Reset = 1'b1; W = 1'b1; Daddress = 20'h00002; Dout = 20'h77777;
    cyc(); W = 1'b0; #1;
    check("rr_out_port", {12'd0, out_port}, 32'd0);
    check("rr_proc_reset", {31'd0, proc_reset}, 32'd1);
    check("rr_load_ready", {31'd0, load_ready}, 32'd1);
    Reset = 1'b0;
    rd("rr_ram2", 20'h00002, 20'hFFFFF);
    load_valid = 1'b1; load_data = 20'h55555; load_last = 1'b1; cyc(); idle();
    rd("reboot_ram0", 20'h00000, 20'h55555);
    rd("reboot_ram1", 20'h00001, 20'hD1230);
    rd("reboot_ram2", 20'h00002, 20'hFFFFF);
    check("reboot_words", {27'd0, boot_words}, 32'd1);

    // Mid-BOOT reset, then full-depth boot without load_last
    Reset = 1'b1; cyc(); Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = 20'hAAA00 + 20'(i); cyc();
    end
    idle(); Reset = 1'b1; cyc(); Reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_data = 20'h10000 + 20'(i); load_last = 1'b0;
      if (i == 15) begin
        #1 check("full_ready_before", {31'd0, load_ready}, 32'd1);
      end
      cyc();
    end
    #1;
    check("full_ready", {31'd0, load_ready}, 32'd0);
    check("full_words", {27'd0, boot_words}, 32'd16);
    load_data = 20'hBAD00; cyc(); idle();
    rd("full_17th_ram0", 20'h00000, 20'h10000);
    rd("full_ram15", 20'h0000F, 20'h1000F);
    check("full_words_hold", {27'd0, boot_words}, 32'd16);

    // load_last coinciding with pointer-full word
    Reset = 1'b1; cyc(); Reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_data = 20'h20000 + 20'(i); load_last = (i == 15);
      cyc();
    end
    idle(); #1;
    check("both_words", {27'd0, boot_words}, 32'd16);
    check("both_ready", {31'd0, load_ready}, 32'd0);
    cyc(); #1;
    check("both_prst", {31'd0, proc_reset}, 32'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/memory_io_unit.md
# memory_io_unit

Memory and I/O subsystem that sits directly downstream of the multicycle processor: it decodes the processor's `Daddress`/`Dout`/`W` bus and returns `DataIn` from a word-addressed unified instruction/data RAM or from memory-mapped I/O registers. It also contains a boot loader. The loader fills the RAM from a streaming load port while holding the processor in reset, then releases it.

## Interface
- `ADDR_W`, default 8: RAM index width; RAM depth = 2^ADDR_W words of 20 bits.
- `Clock`  in  1: single clock; all state updates on its rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Daddress`  in  20: processor address (registered in processor).
- `Dout`  in  20: processor write data.
- `W`  in  1: processor write strobe, sampled at rising edge.
- `DataIn`  out  20: read data to processor; combinational from `Daddress`.
- `load_valid`  in  1: boot word present.
- `load_data`  in  20: boot word.
- `load_last`  in  1: qualifies final boot word.
- `load_ready`  out  1: loader accepting words (high only in BOOT).
- `proc_reset`  out  1: drive to processor `Reset`.
- `in_port`  in  20: asynchronous external input.
- `out_port`  out  20: memory-mapped output register.
- `boot_words`  out  ADDR_W+1: number of words written in the last or current boot.

## Operation
- Two-state FSM: BOOT, RUN. `Reset`=1 forces BOOT, load pointer = 0, `boot_words` = 0, `out_port` = 0, cycle counter = 0, synchronizer flops = 0.
- BOOT:
  - `load_ready`=1.
  - Each cycle with `load_valid`=1 writes `load_data` to RAM[ptr], then ptr and `boot_words` increment.
  - `load_last`=1 with `load_valid`=1 writes that word and moves to RUN.
  - A write to ptr = 2^ADDR_W−1 also moves to RUN, regardless of `load_last`.
  - `W` is ignored in BOOT.
- RUN:
  - `load_ready`=0, and `load_valid` is ignored.
  - The FSM stays in RUN until `Reset`.
- Address map (full 20-bit compare):
  - RAM: `Daddress[19:ADDR_W]`=0; reads and writes RAM[`Daddress[ADDR_W-1:0]`].
  - 20'hFFFF0: `out_port`; read returns the current value, write loads `Dout`.
  - 20'hFFFF1: synchronized `in_port`; read-only.
  - 20'hFFFF2: cycle counter; read-only.
  - Any other address: read returns 0, write has no effect.
  - Writes to read-only addresses are discarded.
- RAM write in RUN: on the rising edge with `W`=1, `Dout` (all 20 bits) is stored at the decoded location.
- Read is asynchronous. `DataIn` reflects the current `Daddress` and current contents.
- `in_port` passes through a 2-flop synchronizer. The read value lags the pin by 2 cycles.
- Cycle counter: 20-bit, increments every RUN cycle, wraps 20'hFFFFF→0, and holds in BOOT.
- RAM contents are not cleared by `Reset`; only the loader overwrites them.

## Timing
- `proc_reset` is registered:
  - 1 during `Reset` and throughout BOOT.
  - 1 in the first RUN cycle.
  - 0 from the second RUN cycle on.
  - This gives the processor one full reset cycle with a stable image.
- Boot throughput: one word per cycle. There is no backpressure inside BOOT.
- Write-to-read:
  - A RAM or `out_port` write at edge N is visible on `DataIn` immediately after edge N when the same address is presented.
  - A write and a read of the same address in the same cycle return the old data before the edge.
- Reset values:
  - `DataIn` = RAM[`Daddress` index] (combinational).
  - `load_ready`=1, `proc_reset`=1, `out_port`=0, `boot_words`=0.
- `Reset` mid-BOOT: ptr returns to 0 and loading restarts; already-written words remain until overwritten.
- `Reset` mid-RUN: FSM returns to BOOT and `proc_reset` rises on the next edge. Any `W` in the reset cycle is ignored.
- `load_valid` and `load_last` asserted on the pointer-full word: a single transition to RUN, and `boot_words` = 2^ADDR_W.

## Test plan
- Boot 3 words (20'h00001, 20'hD1230, 20'hFFFFF, last on third):
  - RAM[0..2] hold those values and `boot_words`=3.
  - `load_ready` falls after the third edge.
  - `proc_reset` drops exactly 2 cycles after the last word.
- Full-depth boot, ADDR_W=4, with 16 words and `load_last` never asserted:
  - RUN is entered after word 16 and `boot_words`=16.
  - A 17th `load_valid` is ignored and RAM[0] is unchanged.
- RUN write/read, `Daddress`=20'h00005:
  - `Dout`=20'hABCDE with `W`=1, then `W`=0 → `DataIn`=20'hABCDE the next cycle.
  - The same write at 20'h00105 (unmapped) leaves `DataIn` at 0 for that address.
- I/O:
  - A write of 20'h0F0F0 to 20'hFFFF0 → `out_port`=20'h0F0F0.
  - `in_port`=20'h12345 changed at cycle k → a read of 20'hFFFF1 returns 20'h12345 from cycle k+2.
  - A write to 20'hFFFF1 has no effect.
- Counter: a read of 20'hFFFF2 returns 0 in the first RUN cycle and 10 ten cycles later. With the counter preset to 20'hFFFFF through the bench, it wraps to 0.
- `Reset` asserted mid-RUN with `W`=1 at 20'h00002:
  - RAM[2] is unchanged, `out_port`=0 and `proc_reset`=1.
  - A reboot of 1 word overwrites only RAM[0].
